// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer.
//   - trap_state_e     : sequencer states
//   - CSREN_*          : one-hot write-enable encodings for the CSR write port
//   - MSTATUS_* / MIE_*: bit positions inside mstatus and mie
//   - *_CAUSE_DEFAULT  : default mcause values for ecall and timer interrupt
package trap_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWMepc,
    StWMcause,
    StWMstatus,
    StRedirect
  } trap_state_e;

  localparam int unsigned CSREN_DEFAULT_W = 8;

  localparam logic [CSREN_DEFAULT_W-1:0] CSREN_MEPC    = 8'b0000_0001;
  localparam logic [CSREN_DEFAULT_W-1:0] CSREN_MCAUSE  = 8'b0000_0010;
  localparam logic [CSREN_DEFAULT_W-1:0] CSREN_MSTATUS = 8'b0000_1000;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIE_MTIE     = 7;

  localparam logic [63:0] ECALL_CAUSE_DEFAULT = 64'hB;
  localparam logic [63:0] IRQ_CAUSE_DEFAULT   = 64'h8000_0000_0000_0007;

endpackage

// File: rtl/trap_mstatus_calc.sv
// Combinational mstatus update for trap entry and mret.
//   mstatus_cur : current mstatus value
//   is_mret     : 1 = mret (exit), 0 = trap entry
//   mstatus_new : updated mstatus
// Entry: MPIE <= MIE, MIE <= 0.  Exit: MIE <= MPIE, MPIE <= 1.
// All other bits pass through unchanged.
module trap_mstatus_calc
  import trap_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] mstatus_cur,
  input  logic            is_mret,
  output logic [XLEN-1:0] mstatus_new
);

  always_comb begin
    mstatus_new = mstatus_cur;
    if (is_mret) begin
      mstatus_new[MSTATUS_MIE]  = mstatus_cur[MSTATUS_MPIE];
      mstatus_new[MSTATUS_MPIE] = 1'b1;
    end else begin
      mstatus_new[MSTATUS_MPIE] = mstatus_cur[MSTATUS_MIE];
      mstatus_new[MSTATUS_MIE]  = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Multi-cycle trap sequencer between writeback and the machine-mode CSR file.
// On a retiring ecall, mret or enabled timer interrupt it stalls writeback,
// flushes younger instructions, writes mepc/mcause/mstatus one per cycle on a
// single CSR write port and finally issues a PC redirect (valid/ready).
//
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   wb_valid/wb_ready     : retiring instruction / writeback may retire (IDLE only)
//   wb_pc, wb_nextpc      : PC and successor PC of the retiring instruction
//   wb_ecall, wb_mret     : retiring instruction kind
//   mstatus_i, mie_i,
//   mtvec_i, mepc_i       : current CSR values
//   timer_irq             : level-sensitive machine timer pending
//   csr_wen, csr_wdata    : one-hot CSR write port (bit0 mepc, bit1 mcause, bit3 mstatus)
//   flush                 : one-cycle pulse killing younger instructions
//   redirect_valid/ready,
//   redirect_pc           : PC redirect handshake
//   busy                  : sequencer not idle
//
// Configuration: define TRAP_CTRL_INTR_EN to enable the machine timer
// interrupt path; otherwise timer_irq and mie_i are ignored.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter int unsigned     CSREN_W     = 8,
  parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(ECALL_CAUSE_DEFAULT),
  parameter logic [XLEN-1:0] IRQ_CAUSE   = XLEN'(IRQ_CAUSE_DEFAULT)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wb_valid,
  output logic               wb_ready,
  input  logic [XLEN-1:0]    wb_pc,
  input  logic [XLEN-1:0]    wb_nextpc,
  input  logic               wb_ecall,
  input  logic               wb_mret,
  input  logic [XLEN-1:0]    mstatus_i,
  input  logic [XLEN-1:0]    mie_i,
  input  logic [XLEN-1:0]    mtvec_i,
  input  logic [XLEN-1:0]    mepc_i,
  input  logic               timer_irq,
  output logic [CSREN_W-1:0] csr_wen,
  output logic [XLEN-1:0]    csr_wdata,
  output logic               flush,
  output logic               redirect_valid,
  input  logic               redirect_ready,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               busy
);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            mret_q, mret_d;

  logic            irq_pending;
  logic            take_ecall, take_mret, take_irq;
  logic            in_idle, accept;
  logic [XLEN-1:0] trap_vector;
  logic [XLEN-1:0] mstatus_new;

  // Interrupt qualification
`ifdef TRAP_CTRL_INTR_EN
  assign irq_pending = timer_irq & mstatus_i[MSTATUS_MIE] & mie_i[MIE_MTIE];

  logic unused_inputs;
  assign unused_inputs = ^{mie_i[XLEN-1:MIE_MTIE+1], mie_i[MIE_MTIE-1:0], mtvec_i[1:0]};
`else
  assign irq_pending = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{timer_irq, mie_i, mtvec_i[1:0]};
`endif

  // Priority ecall > mret > interrupt. An interrupt is only considered when the
  // retiring instruction is neither ecall nor mret; otherwise it stays pending
  // and is looked at again on the next retirement.
  assign take_ecall = wb_valid & wb_ecall;
  assign take_mret  = wb_valid & wb_mret & ~wb_ecall;
  assign take_irq   = wb_valid & ~wb_ecall & ~wb_mret & irq_pending;

  assign in_idle     = (state_q == StIdle);
  // Gated by reset so no flush pulse escapes while the sequencer is held.
  assign accept      = in_idle & ~reset & (take_ecall | take_mret | take_irq);
  // Direct mode only: the mode bits are dropped.
  assign trap_vector = {mtvec_i[XLEN-1:2], 2'b00};

  trap_mstatus_calc #(
    .XLEN (XLEN)
  ) u_mstatus_calc (
    .mstatus_cur (mstatus_i),
    .is_mret     (mret_q),
    .mstatus_new (mstatus_new)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = take_mret ? StWMstatus : StWMepc;
        end
      end
      StWMepc:    state_d = StWMcause;
      StWMcause:  state_d = StWMstatus;
      StWMstatus: state_d = StRedirect;
      StRedirect: begin
        if (redirect_ready) begin
          state_d = StIdle;
        end
      end
      default:    state_d = StIdle;
    endcase
  end

  // Trap context captured at accept and held for the whole sequence
  always_comb begin
    epc_d    = epc_q;
    cause_d  = cause_q;
    target_d = target_q;
    mret_d   = mret_q;
    if (accept) begin
      if (take_ecall) begin
        epc_d    = wb_pc;
        cause_d  = ECALL_CAUSE;
        target_d = trap_vector;
        mret_d   = 1'b0;
      end else if (take_mret) begin
        target_d = mepc_i;
        mret_d   = 1'b1;
      end else begin
        // The interrupted instruction itself completes, so resume after it.
        epc_d    = wb_nextpc;
        cause_d  = IRQ_CAUSE;
        target_d = trap_vector;
        mret_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      epc_q    <= '0;
      cause_q  <= '0;
      target_q <= '0;
      mret_q   <= 1'b0;
    end else begin
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
      mret_q   <= mret_d;
    end
  end

  // Outputs
  always_comb begin
    csr_wen        = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      StWMepc: begin
        csr_wen   = CSREN_W'(CSREN_MEPC);
        csr_wdata = epc_q;
      end
      StWMcause: begin
        csr_wen   = CSREN_W'(CSREN_MCAUSE);
        csr_wdata = cause_q;
      end
      StWMstatus: begin
        // mstatus cannot change while busy, so the live value is still the
        // one seen at accept.
        csr_wen   = CSREN_W'(CSREN_MSTATUS);
        csr_wdata = mstatus_new;
      end
      StRedirect: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
      end
      default: ;
    endcase
  end

  assign busy     = ~in_idle;
  assign wb_ready = in_idle;
  assign flush    = accept;

  // Protocol properties
  a_csr_onehot : assert property (@(posedge clock) disable iff (reset) $onehot0(csr_wen));

  a_redirect_hold : assert property (@(posedge clock) disable iff (reset)
    (redirect_valid && !redirect_ready) |=> (redirect_valid && $stable(redirect_pc)));

  a_no_write_in_redirect : assert property (@(posedge clock) disable iff (reset)
    redirect_valid |-> (csr_wen == '0));

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid, wb_ready;
  logic [63:0] wb_pc, wb_nextpc;
  logic        wb_ecall, wb_mret;
  logic [63:0] mstatus_i, mie_i, mtvec_i, mepc_i;
  logic        timer_irq;
  logic [7:0]  csr_wen;
  logic [63:0] csr_wdata;
  logic        flush;
  logic        redirect_valid, redirect_ready;
  logic [63:0] redirect_pc;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          cyc;
    logic [7:0]  wen;
    logic [63:0] data;
  } exp_csr_t;

  typedef struct {
    int          cyc;
    logic [63:0] pc;
  } exp_rd_t;

  exp_csr_t csr_q[$];
  exp_rd_t  rd_q[$];

  localparam logic [63:0] ECALL_C = 64'hB;
  localparam logic [63:0] IRQ_C   = 64'h8000_0000_0000_0007;

  trap_ctrl u_dut (
    .clock          (clock),
    .reset          (reset),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_pc          (wb_pc),
    .wb_nextpc      (wb_nextpc),
    .wb_ecall       (wb_ecall),
    .wb_mret        (wb_mret),
    .mstatus_i      (mstatus_i),
    .mie_i          (mie_i),
    .mtvec_i        (mtvec_i),
    .mepc_i         (mepc_i),
    .timer_irq      (timer_irq),
    .csr_wen        (csr_wen),
    .csr_wdata      (csr_wdata),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Drives one retirement, then follows the sequence for a bounded number of
  // cycles, popping the scoreboard whenever the DUT writes a CSR or redirects.
  // fetch holds redirect_ready low for 'stall' redirect cycles.
  task automatic run_retire(input string name, input logic ecall, input logic mret,
                            input logic [63:0] pc, input logic [63:0] nextpc,
                            input int stall, input int exp_busy, input logic exp_flush);
    int       busy_n  = 0;
    int       rd_seen = 0;
    exp_csr_t e;
    exp_rd_t  r;
    @(posedge clock); #1;
    wb_valid = 1'b1; wb_ecall = ecall; wb_mret = mret; wb_pc = pc; wb_nextpc = nextpc;
    redirect_ready = 1'b0;
    #1;
    n_checks++;
    if (flush !== exp_flush || wb_ready !== 1'b1)
      $display("FAIL %s_accept: flush=%b wb_ready=%b required flush=%b wb_ready=1",
               name, flush, wb_ready, exp_flush);
    else n_pass++;
    for (int c = 1; c <= exp_busy + stall + 3; c++) begin
      @(posedge clock); #1;
      wb_valid = 1'b0; wb_ecall = 1'b0; wb_mret = 1'b0;
      redirect_ready = redirect_valid && (rd_seen >= stall);
      #1;
      if (!wb_ready) busy_n++;
      if (csr_wen !== 8'h00) begin
        n_checks++;
        if (csr_q.size() == 0) begin
          $display("FAIL %s_csr_extra: cycle %0d wen=%b data=%h required no write",
                   name, c, csr_wen, csr_wdata);
        end else begin
          e = csr_q.pop_front();
          if (csr_wen !== e.wen || csr_wdata !== e.data || c != e.cyc)
            $display("FAIL %s_csr: cycle %0d wen=%b data=%h required cycle %0d wen=%b data=%h",
                     name, c, csr_wen, csr_wdata, e.cyc, e.wen, e.data);
          else n_pass++;
        end
      end
      if (redirect_valid === 1'b1) begin
        n_checks++;
        if (rd_q.size() == 0) begin
          $display("FAIL %s_redirect_extra: cycle %0d pc=%h required no redirect",
                   name, c, redirect_pc);
        end else begin
          r = rd_q[0];
          if (redirect_pc !== r.pc || c != r.cyc + rd_seen)
            $display("FAIL %s_redirect: cycle %0d pc=%h required cycle %0d pc=%h",
                     name, c, redirect_pc, r.cyc + rd_seen, r.pc);
          else n_pass++;
          if (redirect_ready) void'(rd_q.pop_front());
        end
        rd_seen++;
      end else if (redirect_pc !== 64'h0) begin
        n_checks++;
        $display("FAIL %s_redirect_pc_idle: cycle %0d pc=%h required 0", name, c, redirect_pc);
      end
    end
    redirect_ready = 1'b0;
    n_checks++;
    if (busy_n != exp_busy + stall)
      $display("FAIL %s_busy_cycles: got %0d required %0d", name, busy_n, exp_busy + stall);
    else n_pass++;
    n_checks++;
    if (csr_q.size() != 0 || rd_q.size() != 0)
      $display("FAIL %s_missing: csr left %0d redirect left %0d required 0 and 0",
               name, csr_q.size(), rd_q.size());
    else n_pass++;
    csr_q.delete();
    rd_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_checks++;
    if (csr_wen !== 8'h0 || csr_wdata !== 64'h0 || flush !== 1'b0)
      $display("FAIL reset_csr: wen=%b data=%h flush=%b required 0 0 0", csr_wen, csr_wdata, flush);
    else n_pass++;
    n_checks++;
    if (redirect_valid !== 1'b0 || redirect_pc !== 64'h0)
      $display("FAIL reset_redirect: valid=%b pc=%h required 0 0", redirect_valid, redirect_pc);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || wb_ready !== 1'b1)
      $display("FAIL reset_ready: busy=%b wb_ready=%b required 0 1", busy, wb_ready);
    else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock);
  endtask

  task automatic test_ecall();
    mstatus_i = 64'h8; mtvec_i = 64'h8000_1003;
    csr_q.push_back('{cyc: 1, wen: 8'b0000_0001, data: 64'h8000_0010});
    csr_q.push_back('{cyc: 2, wen: 8'b0000_0010, data: ECALL_C});
    csr_q.push_back('{cyc: 3, wen: 8'b0000_1000, data: 64'h80});
    rd_q.push_back('{cyc: 4, pc: 64'h8000_1000});
    run_retire("ecall", 1'b1, 1'b0, 64'h8000_0010, 64'h8000_0014, 0, 4, 1'b1);
  endtask

  task automatic test_mret();
    mstatus_i = 64'h80; mepc_i = 64'h8000_0014;
    csr_q.push_back('{cyc: 1, wen: 8'b0000_1000, data: 64'h88});
    rd_q.push_back('{cyc: 2, pc: 64'h8000_0014});
    run_retire("mret", 1'b0, 1'b1, 64'h8000_0200, 64'h8000_0204, 0, 2, 1'b1);
  endtask

  task automatic test_both_is_ecall();
    mstatus_i = 64'hA; mtvec_i = 64'h8000_2001; mepc_i = 64'h1234;
    csr_q.push_back('{cyc: 1, wen: 8'b0000_0001, data: 64'h8000_0040});
    csr_q.push_back('{cyc: 2, wen: 8'b0000_0010, data: ECALL_C});
    csr_q.push_back('{cyc: 3, wen: 8'b0000_1000, data: 64'h82});
    rd_q.push_back('{cyc: 4, pc: 64'h8000_2000});
    run_retire("ecall_mret", 1'b1, 1'b1, 64'h8000_0040, 64'h8000_0044, 0, 4, 1'b1);
  endtask

  task automatic test_plain_retire();
    mstatus_i = 64'h8; mie_i = 64'h0; timer_irq = 1'b0;
    run_retire("plain", 1'b0, 1'b0, 64'h8000_0030, 64'h8000_0034, 0, 0, 1'b0);
  endtask

  task automatic test_irq();
    mstatus_i = 64'h8; mtvec_i = 64'h8000_1003; timer_irq = 1'b1;
`ifdef TRAP_CTRL_INTR_EN
    mie_i = 64'h80;
    csr_q.push_back('{cyc: 1, wen: 8'b0000_0001, data: 64'h8000_0024});
    csr_q.push_back('{cyc: 2, wen: 8'b0000_0010, data: IRQ_C});
    csr_q.push_back('{cyc: 3, wen: 8'b0000_1000, data: 64'h80});
    rd_q.push_back('{cyc: 4, pc: 64'h8000_1000});
    run_retire("irq", 1'b0, 1'b0, 64'h8000_0020, 64'h8000_0024, 0, 4, 1'b1);
    mie_i = 64'h0;
    run_retire("irq_mie_off", 1'b0, 1'b0, 64'h8000_0020, 64'h8000_0024, 0, 0, 1'b0);
    mie_i = 64'h80; mstatus_i = 64'h0;
    run_retire("irq_mstatus_off", 1'b0, 1'b0, 64'h8000_0020, 64'h8000_0024, 0, 0, 1'b0);
`else
    mie_i = 64'h80;
    run_retire("irq_disabled", 1'b0, 1'b0, 64'h8000_0020, 64'h8000_0024, 0, 0, 1'b0);
`endif
    timer_irq = 1'b0; mie_i = 64'h0; mstatus_i = 64'h8;
  endtask

  task automatic test_ecall_blocks_irq();
    mstatus_i = 64'h8; mtvec_i = 64'h8000_1003; mie_i = 64'h80; timer_irq = 1'b1;
    csr_q.push_back('{cyc: 1, wen: 8'b0000_0001, data: 64'h8000_0050});
    csr_q.push_back('{cyc: 2, wen: 8'b0000_0010, data: ECALL_C});
    csr_q.push_back('{cyc: 3, wen: 8'b0000_1000, data: 64'h80});
    rd_q.push_back('{cyc: 4, pc: 64'h8000_1000});
    run_retire("ecall_over_irq", 1'b1, 1'b0, 64'h8000_0050, 64'h8000_0054, 0, 4, 1'b1);
    // MIE restored by the handler's mret; the still-pending interrupt fires next.
    mstatus_i = 64'h8;
`ifdef TRAP_CTRL_INTR_EN
    csr_q.push_back('{cyc: 1, wen: 8'b0000_0001, data: 64'h8000_0064});
    csr_q.push_back('{cyc: 2, wen: 8'b0000_0010, data: IRQ_C});
    csr_q.push_back('{cyc: 3, wen: 8'b0000_1000, data: 64'h80});
    rd_q.push_back('{cyc: 4, pc: 64'h8000_1000});
    run_retire("irq_after_ecall", 1'b0, 1'b0, 64'h8000_0060, 64'h8000_0064, 0, 4, 1'b1);
`else
    run_retire("irq_after_ecall", 1'b0, 1'b0, 64'h8000_0060, 64'h8000_0064, 0, 0, 1'b0);
`endif
    timer_irq = 1'b0; mie_i = 64'h0;
  endtask

  task automatic test_redirect_stall();
    mstatus_i = 64'h80; mepc_i = 64'h8000_0100;
    csr_q.push_back('{cyc: 1, wen: 8'b0000_1000, data: 64'h88});
    rd_q.push_back('{cyc: 2, pc: 64'h8000_0100});
    run_retire("stall", 1'b0, 1'b1, 64'h8000_0300, 64'h8000_0304, 3, 2, 1'b1);
  endtask

  task automatic test_reset_mid();
    int activity = 0;
    mstatus_i = 64'h8; mtvec_i = 64'h8000_1003;
    @(posedge clock); #1;
    wb_valid = 1'b1; wb_ecall = 1'b1; wb_pc = 64'h8000_0070; wb_nextpc = 64'h8000_0074;
    @(posedge clock); #1;
    wb_valid = 1'b0; wb_ecall = 1'b0;
    @(posedge clock); #2;
    n_checks++;
    if (csr_wen !== 8'b0000_0010 || csr_wdata !== ECALL_C)
      $display("FAIL rmid_mcause: wen=%b data=%h required 00000010 %h", csr_wen, csr_wdata, ECALL_C);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if (csr_wen !== 8'h0 || csr_wdata !== 64'h0 || flush !== 1'b0 || redirect_valid !== 1'b0 ||
        redirect_pc !== 64'h0 || busy !== 1'b0 || wb_ready !== 1'b1)
      $display("FAIL rmid_outputs: wen=%b data=%h flush=%b rv=%b rpc=%h busy=%b ready=%b required all 0, ready 1",
               csr_wen, csr_wdata, flush, redirect_valid, redirect_pc, busy, wb_ready);
    else n_pass++;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #2;
      if (csr_wen !== 8'h0 || redirect_valid !== 1'b0 || busy !== 1'b0) activity++;
    end
    n_checks++;
    if (activity != 0)
      $display("FAIL rmid_abandoned: %0d active cycles after reset required 0", activity);
    else n_pass++;
  endtask

  initial begin
    wb_valid = 1'b0; wb_ecall = 1'b0; wb_mret = 1'b0;
    wb_pc = '0; wb_nextpc = '0;
    mstatus_i = '0; mie_i = '0; mtvec_i = '0; mepc_i = '0;
    timer_irq = 1'b0; redirect_ready = 1'b0;
    test_reset();
    test_ecall();
    test_mret();
    test_both_is_ecall();
    test_plain_retire();
    test_irq();
    test_ecall_blocks_irq();
    test_redirect_stall();
    test_reset_mid();
    test_ecall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
